// File: rtl/mux_n1_pipe_pkg.sv
// Shared constants for the N:1 pipelined multiplexer.
package mux_n1_pipe_pkg;

  localparam logic        MODE_FIXED = 1'b0;
  localparam logic        MODE_RR    = 1'b1;
  localparam int unsigned XFER_CNT_W = 16;

endpackage

// File: rtl/mux_n1_pipe_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo N_CH.
// Only instantiated when MUX_RR_EN is defined.
module mux_n1_pipe_rr_arbiter #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [SEL_W-1:0] cand;

  // Walk the search order backwards so the nearest requester after ptr is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int unsigned i = N_CH; i >= 1; i--) begin
      cand = SEL_W'((32'(ptr) + i) % N_CH);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n1_pipe.sv
// N:1 valid/ready multiplexer with a registered output and transfer counter.
// Define MUX_RR_EN to build the round-robin arbiter selectable through mode_in.
module mux_n1_pipe
  import mux_n1_pipe_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [N_CH-1:0]        valid_in,
  output logic [N_CH-1:0]        ready_out,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   mode_in,
  output logic [DATA_W-1:0]      y_out,
  output logic                   y_valid_out,
  input  logic                   y_ready_in,
  output logic [SEL_W-1:0]       y_ch_out,
  output logic [XFER_CNT_W-1:0]  xfer_cnt_out
);

  logic [DATA_W-1:0]     y_q;
  logic                  y_valid_q;
  logic [SEL_W-1:0]      y_ch_q;
  logic [XFER_CNT_W-1:0] cnt_q;

  logic [SEL_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              acc;
  logic              xfer;
  logic [DATA_W-1:0] data_sel;

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;

  mux_n1_pipe_rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req     (valid_in),
    .ptr     (rr_ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  always_comb begin
    if (mode_in == MODE_RR) begin
      gnt_idx = rr_idx;
      gnt_vld = rr_vld;
    end else begin
      gnt_idx = sel_in;
      gnt_vld = (32'(sel_in) < N_CH);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr_q <= SEL_W'(N_CH - 1);
    end else if (xfer) begin
      rr_ptr_q <= gnt_idx;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode_in;
  assign gnt_idx     = sel_in;
  assign gnt_vld     = (32'(sel_in) < N_CH);
`endif

  assign acc = !y_valid_q | y_ready_in;

  // Ready follows the grant and accept state only, never valid_in of the granted channel.
  always_comb begin
    ready_out = '0;
    xfer      = 1'b0;
    data_sel  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (rst_n_in && gnt_vld && gnt_idx == SEL_W'(k)) begin
        ready_out[k] = acc;
        xfer         = valid_in[k] & acc;
        data_sel     = data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_ch_q    <= '0;
      cnt_q     <= '0;
    end else begin
      if (xfer) begin
        y_q       <= data_sel;
        y_ch_q    <= gnt_idx;
        y_valid_q <= 1'b1;
        cnt_q     <= cnt_q + 1'b1;
      end else if (y_ready_in) begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign y_out        = y_q;
  assign y_valid_out  = y_valid_q;
  assign y_ch_out     = y_ch_q;
  assign xfer_cnt_out = cnt_q;

endmodule
